// File: rtl/gate_truth_sweeper.sv
// gate_truth_sweeper
//   Drives the a/b operand pair of the two-input gate stage through all four
//   combinations. For each vector it waits SETTLE_CYCLES, samples the 8-bit
//   gate result and compares it with the ideal truth table. It reports a
//   verdict, a count of failing vectors and a per-gate failure mask.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ena        : global enable; when low all state holds (the step synchroniser still shifts)
//   start      : level-sampled sweep request (accepted in IDLE/DONE only)
//   step_mode  : 1 = advance vectors on step presses; latched at start
//   step       : asynchronous push-button
//   gate_res   : gate stage results {b, ~a, XNOR, NOR, NAND, XOR, OR, AND}
//   a_out/b_out: registered operands to the gate stage
//   busy       : sweep in progress
//   done       : sweep complete, held until the next accepted start
//   pass       : done with no failing vector
//   err_count  : failing vectors, saturating at 4
//   fail_mask  : OR of (gate_res ^ expected) over all checked vectors
module gate_truth_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       start,
   input  logic       step_mode,
   input  logic       step,
   input  logic [7:0] gate_res,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [7:0] fail_mask
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CHECK,
      S_WAIT_STEP,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             a_q, a_d, b_q, b_d;
   logic             done_q, done_d;
   logic [2:0]       err_q, err_d;
   logic [7:0]       mask_q, mask_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic             step_prev_q;
   logic             step_rise;
   logic             ea, eb;
   logic [7:0]       expected, mismatch;
   logic [1:0]       idx_inc;

   // Synchroniser runs free of ena so a press made while frozen is not lost
   // in the metastability chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], step};
   end

   assign step_rise = sync_q[SYNC_STAGES-1] & ~step_prev_q;

   // Expected results are taken from idx, which always matches a_out/b_out
   // while in CHECK.
   assign ea       = idx_q[0];
   assign eb       = idx_q[1];
   assign expected = {eb, ~ea, ~(ea ^ eb), ~(ea | eb), ~(ea & eb), ea ^ eb, ea | eb, ea & eb};
   assign mismatch = gate_res ^ expected;
   assign idx_inc  = idx_q + 2'd1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      a_d     = a_q;
      b_d     = b_q;
      done_d  = done_q;
      err_d   = err_q;
      mask_d  = mask_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_DRIVE;
               idx_d   = 2'd0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               err_d   = '0;
               mask_d  = '0;
               done_d  = 1'b0;
               mode_d  = step_mode;
            end
         end
         S_DRIVE: begin
            state_d = S_SETTLE;
            cnt_d   = '0;
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
            else                      cnt_d   = cnt_q + 4'd1;
         end
         S_CHECK: begin
            mask_d = mask_q | mismatch;
            if (mismatch != '0 && err_q != 3'd4) err_d = err_q + 3'd1;
            if (idx_q == 2'd3) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (!mode_q) begin
               state_d = S_DRIVE;
               idx_d   = idx_inc;
               a_d     = idx_inc[0];
               b_d     = idx_inc[1];
            end else begin
               state_d = S_WAIT_STEP;
            end
         end
         S_WAIT_STEP: begin
            if (step_rise) begin
               state_d = S_DRIVE;
               idx_d   = idx_inc;
               a_d     = idx_inc[0];
               b_d     = idx_inc[1];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= '0;
         mask_q      <= '0;
         step_prev_q <= 1'b0;
      end else if (ena) begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         a_q         <= a_d;
         b_q         <= b_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mask_q      <= mask_d;
         // Edge history advances in every state, so edges outside WAIT_STEP are consumed.
         step_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign busy      = (state_q == S_DRIVE) || (state_q == S_SETTLE) ||
                      (state_q == S_CHECK) || (state_q == S_WAIT_STEP);
   assign done      = done_q;
   assign pass      = done_q && (err_q == '0);
   assign err_count = err_q;
   assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
module tb_gate_truth_sweeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       start = 1'b0;
   logic       step_mode = 1'b0;
   logic       step = 1'b0;
   logic [7:0] gate_res;
   logic       a_out, b_out, busy, done, pass;
   logic [2:0] err_count;
   logic [7:0] fail_mask;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gate_truth_sweeper #(.SETTLE_CYCLES(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .step_mode(step_mode),
      .step(step), .gate_res(gate_res), .a_out(a_out), .b_out(b_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_mask(fail_mask)
   );

   // Truth-table columns per gate, indexed by vector {b,a}.
   logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                          4'b0001, 4'b1001, 4'b0101, 4'b1100};
   // Fault model of the gate stage: invert, stuck-at-0, stuck-at-1 masks.
   logic [7:0] inv_m = '0, s0_m = '0, s1_m = '0;
   logic [7:0] ideal_res;

   always_comb begin
      ideal_res = '0;
      for (int g = 0; g < 8; g++) ideal_res[g] = tt[g][{b_out, a_out}];
      gate_res = ((ideal_res ^ inv_m) & ~s0_m) | s1_m;
   end

   function automatic logic [7:0] truth(input logic [1:0] v);
      logic [7:0] r;
      for (int g = 0; g < 8; g++) r[g] = tt[g][v];
      return r;
   endfunction

   function automatic logic [7:0] faulty(input logic [1:0] v);
      return ((truth(v) ^ inv_m) & ~s0_m) | s1_m;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int err;
      int mask;
      int pass;
      int len;
   } exp_t;
   exp_t sb[$];

   task automatic push_exp(input int extra_len);
      exp_t e;
      logic [7:0] mm;
      e.err = 0; e.mask = 0;
      for (int v = 0; v < 4; v++) begin
         mm = faulty(2'(v)) ^ truth(2'(v));
         if (mm != 0) e.err++;
         e.mask |= int'(mm);
      end
      if (e.err > 4) e.err = 4;
      e.pass = (e.err == 0) ? 1 : 0;
      e.len  = (extra_len < 0) ? -1 : 4 * (2 + 2) + extra_len;
      sb.push_back(e);
   endtask

   // Monitor: tracks busy length and operand sequence, checks on done rising.
   int   busy_len = 0;
   int   seq[$];
   logic done_d = 1'b0;
   int   seen = 0;

   always @(negedge clk) begin
      exp_t e;
      int code;
      if (!rst_n) begin
         busy_len = 0;
         seq.delete();
         done_d = 1'b0;
      end else begin
         if (busy) begin
            busy_len++;
            if (seq.size() == 0 || seq[$] != int'({b_out, a_out}))
               seq.push_back(int'({b_out, a_out}));
         end
         if (done && !done_d) begin
            seen++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_empty: done seen with no sweep expected at %0t", $time);
            end else begin
               e = sb.pop_front();
               code = 0;
               foreach (seq[i]) code = code * 16 + seq[i];
               chk("err_count", int'(err_count), e.err);
               chk("fail_mask", int'(fail_mask), e.mask);
               chk("pass", int'(pass), e.pass);
               chk("ab_sequence", code, 'h0123);
               if (e.len >= 0) chk("busy_len", busy_len, e.len);
            end
            busy_len = 0;
            seq.delete();
         end
         done_d = done;
      end
   end

   task automatic start_sweep(input logic m);
      @(posedge clk); #1 start = 1'b1; step_mode = m;
      @(posedge clk); #1 start = 1'b0; step_mode = 1'b0;
   endtask

   task automatic wait_seen(input int target, input int budget);
      int n = 0;
      while (seen < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (seen < target) begin
         total++;
         bad++;
         $display("FAIL timeout: sweeps seen %0d expected %0d", seen, target);
      end
   endtask

   task automatic press_check(input int old_v, input int new_v);
      step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      @(posedge clk); #1 chk("step_hold", int'({b_out, a_out}), old_v);
      @(posedge clk); #1 chk("step_adv", int'({b_out, a_out}), new_v);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_a"}, int'(a_out), 0);
      chk({tag, "_b"}, int'(b_out), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_err"}, int'(err_count), 0);
      chk({tag, "_mask"}, int'(fail_mask), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 chk_zero_outputs("reset");
      rst_n = 1'b1;

      // Healthy gate stage.
      push_exp(0); start_sweep(1'b0); wait_seen(1, 60);
      chk("clean_pass", int'(pass), 1);

      // XOR output inverted on every vector.
      inv_m = 8'h04; push_exp(0); start_sweep(1'b0); wait_seen(2, 60);
      chk("xor_inv_err", int'(err_count), 4);
      chk("xor_inv_mask", int'(fail_mask), 'h04);

      // AND output stuck at 0: only a=1,b=1 fails.
      inv_m = '0; s0_m = 8'h01; push_exp(0); start_sweep(1'b0); wait_seen(3, 60);
      chk("and_s0_err", int'(err_count), 1);
      chk("and_s0_mask", int'(fail_mask), 'h01);

      // Step mode, with one press landing in SETTLE that must be discarded.
      s0_m = '0; inv_m = 8'h80; push_exp(-1); start_sweep(1'b1);
      repeat (20) @(posedge clk); #1;
      chk("step_wait_busy", int'(busy), 1);
      chk("step_wait_ab", int'({b_out, a_out}), 0);
      press_check(0, 1);
      step = 1'b1; @(posedge clk); #1 step = 1'b0;
      repeat (20) @(posedge clk); #1;
      chk("spurious_ab", int'({b_out, a_out}), 1);
      chk("spurious_done", int'(done), 0);
      press_check(1, 2);
      repeat (20) @(posedge clk); #1;
      chk("two_press_done", int'(done), 0);
      press_check(2, 3);
      wait_seen(4, 60);

      // ena low for 5 cycles mid-sweep stretches busy by exactly 5.
      inv_m = '0; push_exp(5); start_sweep(1'b0);
      repeat (5) @(posedge clk); #1 ena = 1'b0;
      repeat (5) @(posedge clk); #1 ena = 1'b1;
      wait_seen(5, 60);

      // Reset during vector 2, then a clean sweep with ignored start pulses.
      start_sweep(1'b0);
      repeat (9) @(posedge clk); #2 rst_n = 1'b0;
      #1 chk_zero_outputs("midreset");
      @(posedge clk); #2 rst_n = 1'b1;
      push_exp(0); start_sweep(1'b0);
      repeat (4) @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_seen(6, 60);

      // start held high relaunches on completion.
      push_exp(0); push_exp(0);
      @(posedge clk); #1 start = 1'b1;
      wait_seen(7, 60);
      start = 1'b0;
      wait_seen(8, 60);

      // Randomised fault patterns.
      for (int k = 0; k < 8; k++) begin
         inv_m = 8'($urandom & $urandom & $urandom);
         s0_m  = 8'($urandom & $urandom & $urandom);
         s1_m  = 8'($urandom & $urandom & $urandom);
         push_exp(0); start_sweep(1'b0); wait_seen(9 + k, 60);
      end

      repeat (3) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
